// File: rtl/disp_scan_ctrl.sv
// Time-multiplexed 8-digit 7-segment scan controller with blanking dead-time between digits.
// Optional blink support is compiled in when the macro SCAN_BLINK_EN is defined.
module disp_scan_ctrl #(
    parameter int SCAN_DIV  = 12500,
    parameter int BLANK_CYC = 16,
    parameter int BLINK_DIV = 25000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [10:0] num,
    input  logic [7:0]  blink_mask,
    output logic [2:0]  light,
    output logic [7:0]  an,
    output logic [7:0]  seg,
    output logic        frame_start
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(SCAN_DIV - BLANK_CYC - 1);

    typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       light_nxt;
    logic [7:0]       an_nxt, seg_nxt;
    logic             frame_start_nxt;
    logic             blank_digit;

    function automatic logic [7:0] decode(input logic [10:0] code);
        case (code)
            11'd0:   decode = 8'hC0;
            11'd1:   decode = 8'hF9;
            11'd2:   decode = 8'hA4;
            11'd3:   decode = 8'hB0;
            11'd4:   decode = 8'h99;
            11'd5:   decode = 8'h92;
            11'd6:   decode = 8'h82;
            11'd7:   decode = 8'hF8;
            11'd8:   decode = 8'h80;
            11'd9:   decode = 8'h90;
            11'd11:  decode = 8'hBF;
            default: decode = 8'hFF;
        endcase
    endfunction

`ifdef SCAN_BLINK_EN
    localparam int BLINK_W = $clog2(BLINK_DIV + 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_phase;

    // Blink timebase is free-running so blinking digits stay in step across enable toggles
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    assign blank_digit = blink_phase & blink_mask[light];
`else
    logic unused_blink;
    assign unused_blink = ^blink_mask;
    assign blank_digit  = 1'b0;
`endif

    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        light_nxt       = light;
        an_nxt          = an;
        seg_nxt         = seg;
        frame_start_nxt = 1'b0;
        if (!enable) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            light_nxt = 3'd0;
            an_nxt    = 8'hFF;
            seg_nxt   = 8'hFF;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = BLANK;
                    cnt_nxt   = '0;
                    light_nxt = 3'd0;
                    an_nxt    = 8'hFF;
                    seg_nxt   = 8'hFF;
                end
                // num has had the whole blank period to settle from light before it is latched
                BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        seg_nxt   = blank_digit ? 8'hFF : decode(num);
                        an_nxt    = ~(8'd1 << light);
                        state_nxt = DRIVE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                DRIVE: begin
                    if (cnt == DRIVE_LAST) begin
                        an_nxt          = 8'hFF;
                        seg_nxt         = 8'hFF;
                        light_nxt       = light + 3'd1;
                        frame_start_nxt = (light == 3'd7);
                        state_nxt       = BLANK;
                        cnt_nxt         = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    light_nxt = 3'd0;
                    an_nxt    = 8'hFF;
                    seg_nxt   = 8'hFF;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            light       <= 3'd0;
            an          <= 8'hFF;
            seg         <= 8'hFF;
            frame_start <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            light       <= light_nxt;
            an          <= an_nxt;
            seg         <= seg_nxt;
            frame_start <= frame_start_nxt;
        end
    end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Self-checking bench for disp_scan_ctrl: a timeline-based reference model, a decode table and corner sequences.
// Works with or without SCAN_BLINK_EN defined.
module tb_disp_scan_ctrl;

    localparam int SCAN_DIV  = 8;
    localparam int BLANK_CYC = 2;
    localparam int BLINK_DIV = 64;
    localparam int FRAME     = 8 * SCAN_DIV;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [7:0]  blink_mask = 8'h00;
    logic        force_en = 1'b0;
    logic [10:0] force_val = 11'd0;
    logic [10:0] num;
    logic [2:0]  light;
    logic [7:0]  an;
    logic [7:0]  seg;
    logic        frame_start;

    int checks = 0;
    int failures = 0;

    // Reference model: position on the scan timeline since the scan started
    bit         m_run = 1'b0;
    int         m_t = 0;
    int         m_k = 0;
    logic [7:0] m_seg = 8'hFF;

    logic [7:0] font [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                              8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    typedef struct {
        logic [10:0] code;
        logic [7:0]  exp_seg;
    } dec_vec_t;

    dec_vec_t vecs [16];

    assign num = force_en ? force_val : {8'd0, light};

    disp_scan_ctrl #(
        .SCAN_DIV (SCAN_DIV),
        .BLANK_CYC(BLANK_CYC),
        .BLINK_DIV(BLINK_DIV)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .num        (num),
        .blink_mask (blink_mask),
        .light      (light),
        .an         (an),
        .seg        (seg),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ref_decode(input logic [10:0] code);
        if (code < 11'd10) return font[int'(code)];
        if (code == 11'd11) return 8'hBF;
        return 8'hFF;
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        int         d;
        logic [10:0] nv;
        if (!rst_n) begin
            m_run = 1'b0;
            m_t   = 0;
            m_k   = 0;
            m_seg = 8'hFF;
            return;
        end
        d = (m_t / SCAN_DIV) % 8;
        if (!enable) begin
            m_run = 1'b0;
        end else if (!m_run) begin
            m_run = 1'b1;
            m_t   = 0;
        end else begin
            nv = force_en ? force_val : 11'(d);
            if (m_t % SCAN_DIV == BLANK_CYC - 1) begin
                m_seg = ref_decode(nv);
`ifdef SCAN_BLINK_EN
                if (((m_k / BLINK_DIV) % 2 == 1) && blink_mask[d]) m_seg = 8'hFF;
`endif
            end
            m_t++;
        end
        m_k++;
    endtask

    task automatic check_model();
        int         pos, d;
        logic [7:0] e_an, e_seg;
        logic [2:0] e_light;
        logic       e_fs;
        if (!m_run) begin
            e_an = 8'hFF; e_seg = 8'hFF; e_light = 3'd0; e_fs = 1'b0;
        end else begin
            pos     = m_t % SCAN_DIV;
            d       = (m_t / SCAN_DIV) % 8;
            e_light = 3'(d);
            e_fs    = (m_t > 0) && (m_t % FRAME == 0);
            if (pos < BLANK_CYC) begin
                e_an = 8'hFF; e_seg = 8'hFF;
            end else begin
                e_an = ~(8'd1 << d); e_seg = m_seg;
            end
        end
        checkOutput("model_an", {8'd0, an}, {8'd0, e_an});
        checkOutput("model_seg", {8'd0, seg}, {8'd0, e_seg});
        checkOutput("model_light", {13'd0, light}, {13'd0, e_light});
        checkOutput("model_frame_start", {15'd0, frame_start}, {15'd0, e_fs});
    endtask

    // One clock: model follows the edge, outputs compared 1ns later
    task automatic applyStimulus();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    initial begin
        int fs_count;
        int blink_hits;

        vecs[0]  = '{11'd0,    8'hC0};
        vecs[1]  = '{11'd1,    8'hF9};
        vecs[2]  = '{11'd2,    8'hA4};
        vecs[3]  = '{11'd3,    8'hB0};
        vecs[4]  = '{11'd4,    8'h99};
        vecs[5]  = '{11'd5,    8'h92};
        vecs[6]  = '{11'd6,    8'h82};
        vecs[7]  = '{11'd7,    8'hF8};
        vecs[8]  = '{11'd8,    8'h80};
        vecs[9]  = '{11'd9,    8'h90};
        vecs[10] = '{11'd10,   8'hFF};
        vecs[11] = '{11'd11,   8'hBF};
        vecs[12] = '{11'd12,   8'hFF};
        vecs[13] = '{11'd13,   8'hFF};
        vecs[14] = '{11'd100,  8'hFF};
        vecs[15] = '{11'd2047, 8'hFF};

        // Reset held three edges with enable high
        rst_n = 1'b0; enable = 1'b1;
        repeat (3) applyStimulus();
        checkOutput("reset_an", {8'd0, an}, 16'h00FF);
        checkOutput("reset_seg", {8'd0, seg}, 16'h00FF);
        checkOutput("reset_light", {13'd0, light}, 16'd0);
        checkOutput("reset_frame_start", {15'd0, frame_start}, 16'd0);
        rst_n = 1'b1;
        #2;
        checkOutput("release_no_change_an", {8'd0, an}, 16'h00FF);
        checkOutput("release_no_change_light", {13'd0, light}, 16'd0);

        // Free scan with num following light; two frame wraps in 130 cycles
        fs_count = 0;
        for (int i = 0; i < 130; i++) begin
            applyStimulus();
            if (frame_start) fs_count++;
            if (i == 2) begin
                checkOutput("scan_d0_an", {8'd0, an}, 16'h00FE);
                checkOutput("scan_d0_seg", {8'd0, seg}, 16'h00C0);
            end
            if (i == 10) begin
                checkOutput("scan_d1_an", {8'd0, an}, 16'h00FD);
                checkOutput("scan_d1_seg", {8'd0, seg}, 16'h00F9);
            end
        end
        checkOutput("frame_start_count", 16'(fs_count), 16'd2);

        // Decode table, each code latched into digit 0 after a fresh restart
        blink_mask = 8'h00;
        for (int v = 0; v < 16; v++) begin
            enable = 1'b0; force_en = 1'b1; force_val = vecs[v].code;
            applyStimulus();
            enable = 1'b1;
            repeat (3) applyStimulus();
            checkOutput($sformatf("decode_seg_%0d", vecs[v].code), {8'd0, seg}, {8'd0, vecs[v].exp_seg});
            checkOutput($sformatf("decode_an_%0d", vecs[v].code), {8'd0, an}, 16'h00FE);
        end

        // enable dropped during digit 3 drive, then restart
        enable = 1'b0; force_en = 1'b0;
        applyStimulus();
        enable = 1'b1;
        applyStimulus();
        repeat (28) applyStimulus();
        checkOutput("d3_driving_an", {8'd0, an}, 16'h00F7);
        enable = 1'b0;
        applyStimulus();
        checkOutput("disable_an", {8'd0, an}, 16'h00FF);
        checkOutput("disable_seg", {8'd0, seg}, 16'h00FF);
        checkOutput("disable_light", {13'd0, light}, 16'd0);
        enable = 1'b1;
        applyStimulus();
        applyStimulus();
        checkOutput("restart_blank_an", {8'd0, an}, 16'h00FF);
        applyStimulus();
        checkOutput("restart_drive_an", {8'd0, an}, 16'h00FE);

        // num changes mid-drive of digit 5; takes effect at digit 6
        repeat (41) applyStimulus();
        force_en = 1'b1; force_val = 11'd0;
        applyStimulus();
        checkOutput("hold_d5_seg", {8'd0, seg}, 16'h0092);
        checkOutput("hold_d5_an", {8'd0, an}, 16'h00DF);
        repeat (6) applyStimulus();
        checkOutput("latch_d6_seg", {8'd0, seg}, 16'h00C0);
        checkOutput("latch_d6_an", {8'd0, an}, 16'h00BF);
        rst_n = 1'b0;
        applyStimulus();
        checkOutput("mid_reset_an", {8'd0, an}, 16'h00FF);
        checkOutput("mid_reset_seg", {8'd0, seg}, 16'h00FF);
        checkOutput("mid_reset_light", {13'd0, light}, 16'd0);
        rst_n = 1'b1; force_en = 1'b0;

        // Blink on digits 0 and 1
        blink_mask = 8'h03;
        blink_hits = 0;
        for (int i = 0; i < 200; i++) begin
            applyStimulus();
            if ((an == 8'hFE || an == 8'hFD) && seg == 8'hFF) blink_hits++;
        end
`ifdef SCAN_BLINK_EN
        checkOutput("blink_seen", {15'd0, blink_hits > 0}, 16'd1);
`else
        checkOutput("blink_absent", 16'(blink_hits), 16'd0);
`endif

        // Randomized run against the reference model
        for (int i = 0; i < 1500; i++) begin
            rst_n  = ($urandom_range(0, 199) != 0);
            enable = ($urandom_range(0, 149) != 0);
            if ($urandom_range(0, 19) == 0) force_en = ~force_en;
            if ($urandom_range(0, 9) == 0) force_val = 11'($urandom_range(0, 15));
            if ($urandom_range(0, 99) == 0) force_val = 11'($urandom_range(0, 2047));
            if ($urandom_range(0, 63) == 0) blink_mask = 8'($urandom);
            applyStimulus();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/disp_scan_ctrl.md
Name: disp_scan_ctrl

Overview:
- Time-multiplexed scan controller for the 8-digit 7-segment display.
- Drives the digit index `light` into the digit-value mux and samples the returned `num` code.
- Converts the code to active-low segments and drives active-low anodes.
- Inserts a blanking dead-time between digits. The mux output settles during blanking, which prevents ghosting.

Parameters:
- SCAN_DIV, 12500: clock cycles per digit slot (blank plus drive). Constraint: SCAN_DIV > BLANK_CYC.
- BLANK_CYC, 16: cycles at the start of each slot with all anodes off. Constraint: BLANK_CYC >= 1.
- BLINK_DIV, 25000000: cycles per blink half-period (used only with SCAN_BLINK_EN).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- enable  in  1  display on; 0 forces IDLE
- num  in  11  digit code for the current `light`; 0-9 digit, 11 dash, 12 blank, other values blank
- blink_mask  in  8  per-digit blink request; bit i refers to digit i
- light  out  3  digit index presented to the value mux
- an  out  8  anode enables, active-low, one-hot-low while driving
- seg  out  8  active-low segments; seg[7]=dp (always 1), seg[6:0]=gfedcba
- frame_start  out  1  one-cycle pulse when `light` wraps 7->0

Behaviour:
- Reset (rst_n=0 at a clk edge, synchronous only) sets:
  - state=IDLE, light=0, an=8'hFF, seg=8'hFF, frame_start=0, all counters 0.
- States: IDLE, BLANK, DRIVE. A slot counter `cnt` counts within each state.
- IDLE:
  - an=FF, seg=FF, light=0.
  - If enable=1, go to BLANK with cnt=0.
- BLANK:
  - an=FF.
  - `light` is held stable; `num` is treated as combinational from `light` and settles here.
  - cnt counts 0..BLANK_CYC-1.
  - On cnt=BLANK_CYC-1:
    - seg <= decode(num) (blink override applies, see Optional Feature).
    - an <= ~(8'b1 << light).
    - Go to DRIVE with cnt=0.
- DRIVE:
  - an and seg are held.
  - cnt counts 0..SCAN_DIV-BLANK_CYC-1.
  - On the last count:
    - an <= FF, seg <= FF.
    - light <= light+1, wrapping 7->0.
    - Go to BLANK with cnt=0.
- frame_start=1 for exactly the one cycle after the DRIVE->BLANK transition where light went 7->0. It is never asserted from IDLE entry.
- Slot timing: each digit is driven for SCAN_DIV-BLANK_CYC cycles and preceded by BLANK_CYC blank cycles. A full frame is 8*SCAN_DIV cycles.
- Decode table (active-low):
  - 0->C0, 1->F9, 2->A4, 3->B0, 4->99
  - 5->92, 6->82, 7->F8, 8->80, 9->90
  - 11->BF; 10, 12 and all codes >12 -> FF.
- num is sampled only on the final BLANK cycle. Changes to num during DRIVE have no effect until the next slot.
- enable=0 in any state: the next edge goes to IDLE (an=FF, seg=FF, light=0, cnt=0, frame_start=0). There is no partial-slot completion.
- enable re-asserted: the scan restarts at digit 0 with a full BLANK period.
- Reset has priority over enable. Reset mid-slot discards the slot.

Optional Feature:
- Macro SCAN_BLINK_EN.
- Defined:
  - A free-running blink counter (reset 0, runs regardless of enable) toggles blink_phase every BLINK_DIV cycles. blink_phase resets to 0.
  - When seg is latched at the end of BLANK: if blink_phase=1 and blink_mask[light]=1, seg <= FF. an is still driven normally.
  - blink_mask is sampled at the same edge as num.
- Not defined:
  - No blink counter exists; blink_mask is ignored.
  - seg is always decode(num).

Test Plan (SCAN_DIV=8, BLANK_CYC=2, BLINK_DIV=64):
- Reset: hold rst_n=0 3 edges with enable=1 -> an=FF, seg=FF, light=0, frame_start=0. Deassert rst_n between edges -> no change until the next edge.
- Scan with num=light (behavioural mux): enable=1 -> per slot, 2 cycles an=FF then 6 cycles of FE,FD,FB,F7,EF,DF,BF,7F. seg is C0,F9,A4,B0,99,92,82,F8 respectively. frame_start pulses once every 64 cycles.
- Decode edge codes: num forced to 11 -> seg=BF. Forced to 10, 12, 2047 -> seg=FF while an remains one-hot-low.
- enable=0 during DRIVE of digit 3 -> next cycle an=FF, seg=FF, light=0. enable=1 again -> 2 blank cycles, then an=FE.
- Blink (macro defined): blink_mask=8'h03 -> digits 0,1 show seg=FF with an active during blink_phase=1 (cycles 64-127), normal C0/F9 during phase 0. Macro undefined -> always normal.
- num changes mid-DRIVE of digit 5 -> seg unchanged until digit 6 latches. rst_n=0 mid-DRIVE -> next edge gives reset values.
